// File: rtl/rock_pkg.sv
// Shared definitions for the cradle rocking path (controller <-> rock_driver).
package rock_pkg;

  // Motion state encoding, visible on the driver's state output.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ROCK = 2'b01,
    ST_HOME = 2'b10
  } rock_state_e;

  // Decoded command; enum order documents priority (Fmin > Fplus > Amin).
  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_FMIN  = 2'd1,
    CMD_FPLUS = 2'd2,
    CMD_AMIN  = 2'd3
  } rock_cmd_e;

  // Default settings shared with the controller.
  localparam int FREQ_DEF     = 64;
  localparam int AMP_DEF      = 8;
  localparam int FREQ_MIN_DEF = 8;
  localparam int FREQ_MAX_DEF = 200;

  // Pick the single highest-priority asserted command.
  function automatic rock_cmd_e cmd_pick(input logic fmin, input logic fplus,
                                         input logic amin);
    rock_cmd_e c;
    c = CMD_NONE;
    if (fmin)       c = CMD_FMIN;
    else if (fplus) c = CMD_FPLUS;
    else if (amin)  c = CMD_AMIN;
    return c;
  endfunction

  // True when two or more commands are asserted together.
  function automatic logic cmd_multi(input logic fmin, input logic fplus,
                                     input logic amin);
    return (fmin & fplus) | (fmin & amin) | (fplus & amin);
  endfunction

endpackage

// File: rtl/rock_step_gen.sv
// Phase accumulator and registered step pulse for the cradle motor stage.
module rock_step_gen #(
  parameter int FREQ_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [FREQ_W-1:0] freq,
  output logic              carry,
  output logic              step
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;

  // One extra bit on the sum so the overflow is the step event.
  always_comb sum = {1'b0, acc} + (ACC_W+1)'(freq);

  assign carry = en & sum[ACC_W];

  // Accumulate while enabled; hold at zero otherwise so a restart begins from a clean phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc  <= '0;
      step <= 1'b0;
    end else if (!en) begin
      acc  <= '0;
      step <= 1'b0;
    end else begin
      acc  <= sum[ACC_W-1:0];
      step <= sum[ACC_W];
    end
  end

endmodule

// File: rtl/rock_driver.sv
// Cradle actuator driver: frequency/amplitude settings, symmetric swing, IDLE/ROCK/HOME FSM.
module rock_driver
  import rock_pkg::*;
#(
  parameter int FREQ_W    = 8,
  parameter int AMP_W     = 4,
  parameter int ACC_W     = 16,
  parameter int FREQ_MIN  = FREQ_MIN_DEF,
  parameter int FREQ_MAX  = FREQ_MAX_DEF,
  parameter int FREQ_INIT = FREQ_DEF,
  parameter int AMP_INIT  = AMP_DEF,
  parameter int UPD_DIV   = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    Fmin,
  input  logic                    Fplus,
  input  logic                    Amin,
  output logic                    step,
  output logic                    dir,
  output logic [FREQ_W-1:0]       freq,
  output logic [AMP_W-1:0]        amp,
  output logic signed [AMP_W:0]   pos,
  output logic [1:0]              state,
  output logic                    cmd_err
);

  localparam int CNT_W = (UPD_DIV > 2) ? $clog2(UPD_DIV) : 1;
  localparam logic signed [AMP_W:0] ONE = 1;

  logic [CNT_W-1:0]      upd_cnt;
  logic                  sample;
  logic                  carry;
  rock_cmd_e             cmd;
  logic                  restart;
  rock_state_e           st, st_nxt;
  logic [FREQ_W-1:0]     freq_nxt;
  logic [AMP_W-1:0]      amp_nxt;
  logic                  dir_nxt;
  logic signed [AMP_W:0] pos_nxt;
  logic signed [AMP_W:0] amp_s;

  assign state  = st;
  assign sample = (upd_cnt == CNT_W'(UPD_DIV - 1));

  rock_step_gen #(
    .FREQ_W (FREQ_W),
    .ACC_W  (ACC_W)
  ) u_step_gen (
    .clk   (clk),
    .reset (reset),
    .en    (st != ST_IDLE),
    .freq  (freq),
    .carry (carry),
    .step  (step)
  );

  // Free-running command sample divider, independent of motion state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      upd_cnt <= '0;
    else if (sample) upd_cnt <= '0;
    else             upd_cnt <= upd_cnt + CNT_W'(1);
  end

  // Settings update, swing direction/position and next state.
  always_comb begin
    cmd      = sample ? cmd_pick(Fmin, Fplus, Amin) : CMD_NONE;
    restart  = ((cmd == CMD_FMIN) || (cmd == CMD_FPLUS)) && (st != ST_ROCK);
    freq_nxt = freq;
    amp_nxt  = amp;
    dir_nxt  = dir;
    pos_nxt  = pos;
    st_nxt   = st;
    amp_s    = $signed({1'b0, amp});

    case (cmd)
      CMD_FMIN:  freq_nxt = (freq > FREQ_W'(FREQ_MIN)) ? freq - FREQ_W'(1) : FREQ_W'(FREQ_MIN);
      CMD_FPLUS: freq_nxt = (freq < FREQ_W'(FREQ_MAX)) ? freq + FREQ_W'(1) : FREQ_W'(FREQ_MAX);
      CMD_AMIN:  amp_nxt  = (amp != '0) ? amp - AMP_W'(1) : '0;
      default:   ;
    endcase
    if (restart) amp_nxt = AMP_W'(AMP_INIT);

    // Turn-around uses the amplitude held before this cycle's update, so a
    // reduction sampled on a step cycle only bites on the following step.
    if (carry) begin
      if (dir && (pos >= amp_s))       dir_nxt = 1'b0;
      else if (!dir && (pos <= -amp_s)) dir_nxt = 1'b1;
      pos_nxt = dir_nxt ? pos + ONE : pos - ONE;
    end

    if (restart) st_nxt = ST_ROCK;
    else begin
      case (st)
        ST_ROCK: if (amp_nxt == '0) st_nxt = ST_HOME;
        ST_HOME: if (pos_nxt == '0) st_nxt = ST_IDLE;
        default: ;
      endcase
    end

    // Parked cradle always restarts heading positive.
    if (st_nxt == ST_IDLE) dir_nxt = 1'b1;
  end

  // Settings, motion and error flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      freq    <= FREQ_W'(FREQ_INIT);
      amp     <= AMP_W'(AMP_INIT);
      pos     <= '0;
      dir     <= 1'b1;
      st      <= ST_ROCK;
      cmd_err <= 1'b0;
    end else begin
      freq    <= freq_nxt;
      amp     <= amp_nxt;
      pos     <= pos_nxt;
      dir     <= dir_nxt;
      st      <= st_nxt;
      cmd_err <= cmd_err | (sample & cmd_multi(Fmin, Fplus, Amin));
    end
  end

endmodule

// File: tb/tb_rock_driver.sv
// Scoreboard bench for rock_driver: stimulus pushes expectations, monitor pops on DUT output events.
module tb_rock_driver;
  import rock_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              Fmin = 1'b0, Fplus = 1'b0, Amin = 1'b0;
  logic              step, dir, cmd_err;
  logic [7:0]        freq;
  logic [3:0]        amp;
  logic signed [4:0] pos;
  logic [1:0]        state;

  rock_driver #(
    .FREQ_W(8), .AMP_W(4), .ACC_W(8), .FREQ_MIN(8), .FREQ_MAX(200),
    .FREQ_INIT(64), .AMP_INIT(8), .UPD_DIV(4)
  ) dut (
    .clk(clk), .reset(reset), .Fmin(Fmin), .Fplus(Fplus), .Amin(Amin),
    .step(step), .dir(dir), .freq(freq), .amp(amp), .pos(pos),
    .state(state), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int pos; bit dir; } step_t;
  typedef struct { int freq; int amp; bit err; } set_t;

  step_t      step_q[$];
  set_t       set_q[$];
  logic [1:0] st_q[$];

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   chk_steps = 1'b0;

  logic [7:0] p_freq;
  logic [3:0] p_amp;
  logic       p_err;
  logic [1:0] p_state;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_step(input int c, input int p, input bit d);
    step_t e; e.cyc = c; e.pos = p; e.dir = d; step_q.push_back(e);
  endtask

  task automatic push_set(input int f, input int a, input bit er);
    set_t e; e.freq = f; e.amp = a; e.err = er; set_q.push_back(e);
  endtask

  task automatic check_reset(input string tag);
    check({tag, " freq"},    freq,    64);
    check({tag, " amp"},     amp,     8);
    check({tag, " pos"},     pos,     0);
    check({tag, " dir"},     dir,     1);
    check({tag, " step"},    step,    0);
    check({tag, " state"},   state,   ST_ROCK);
    check({tag, " cmd_err"}, cmd_err, 0);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Present a command so that exactly the sample edge e catches it.
  task automatic drive_at(input int e, input logic f, input logic p, input logic a);
    wait_cyc(e - 1);
    Fmin = f; Fplus = p; Amin = a;
    wait_cyc(e);
    Fmin = 1'b0; Fplus = 1'b0; Amin = 1'b0;
  endtask

  // Monitor: one sample per clock, 1ns after the rising edge.
  always @(posedge clk) begin
    step_t      se;
    set_t       ce;
    logic [1:0] sv;
    #1;
    if (!reset) begin
      cyc = 0;
    end else begin
      cyc++;
      if (step) begin
        if (chk_steps) begin
          if (step_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL step extra: got step pos %0d at cyc %0d, want none", pos, cyc);
          end else begin
            se = step_q.pop_front();
            check("step cyc", cyc, se.cyc);
            check("step pos", pos, se.pos);
            check("step dir", dir, se.dir);
          end
        end else begin
          check("pos bound", (pos > 5'sd8) || (pos < -5'sd8), 0);
        end
      end
      if ((freq != p_freq) || (amp != p_amp) || (cmd_err != p_err)) begin
        if (set_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL setting extra: got freq %0d amp %0d err %0d, want no change", freq, amp, cmd_err);
        end else begin
          ce = set_q.pop_front();
          check("set freq", freq, ce.freq);
          check("set amp",  amp,  ce.amp);
          check("set err",  cmd_err, ce.err);
        end
      end
      if (state != p_state) begin
        if (st_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL state extra: got %0d, want %0d", state, p_state);
        end else begin
          sv = st_q.pop_front();
          check("state", state, sv);
        end
      end
    end
    p_freq = freq; p_amp = amp; p_err = cmd_err; p_state = state;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b0;
    #1 check_reset("por");
    @(negedge clk); @(negedge clk);

    // Phase 1: swing, amplitude run-down to HOME/IDLE, restart from IDLE.
    push_step(4, 1, 1);   push_step(8, 2, 1);   push_step(12, 3, 1);
    push_step(16, 4, 1);  push_step(20, 5, 1);  push_step(24, 6, 1);
    push_step(28, 7, 1);  push_step(32, 6, 0);  push_step(36, 5, 0);
    push_step(40, 4, 0);  push_step(44, 3, 0);  push_step(48, 2, 0);
    push_step(52, 1, 0);  push_step(56, 0, 0);  push_step(60, -1, 0);
    push_step(64, 0, 1);  push_step(77, 1, 1);  push_step(81, 2, 1);
    push_step(85, 3, 1);
    push_set(64, 7, 0); push_set(64, 6, 0); push_set(64, 5, 0); push_set(64, 4, 0);
    push_set(64, 3, 0); push_set(64, 2, 0); push_set(64, 1, 0); push_set(64, 0, 0);
    push_set(63, 8, 0);
    st_q.push_back(ST_HOME); st_q.push_back(ST_IDLE); st_q.push_back(ST_ROCK);
    chk_steps = 1'b1;
    reset = 1'b1;
    drive_at(24, 0, 0, 1);
    drive_at(32, 0, 0, 1); drive_at(36, 0, 0, 1); drive_at(40, 0, 0, 1);
    drive_at(44, 0, 0, 1); drive_at(48, 0, 0, 1); drive_at(52, 0, 0, 1);
    drive_at(60, 0, 0, 1);
    wait_cyc(68);
    check("idle state", state, ST_IDLE);
    check("idle pos", pos, 0);
    drive_at(72, 1, 0, 0);
    wait_cyc(86);
    #2 reset = 1'b0;
    #1 check_reset("mid-swing");
    @(negedge clk);

    // Phase 2: conflicting commands, then frequency saturation both ways.
    push_step(4, 1, 1);
    push_set(63, 8, 1); push_set(64, 8, 1);
    for (int v = 65; v <= 200; v++) push_set(v, 8, 1);
    for (int v = 199; v >= 8; v--)  push_set(v, 8, 1);
    reset = 1'b1;
    drive_at(4, 1, 0, 1);
    chk_steps = 1'b0;
    drive_at(8, 0, 1, 0);
    Fplus = 1'b1;
    repeat (800) @(negedge clk);
    Fplus = 1'b0;
    check("freq max", freq, 200);
    Fmin = 1'b1;
    repeat (800) @(negedge clk);
    Fmin = 1'b0;
    check("freq min", freq, 8);
    check("amp kept", amp, 8);
    check("err sticky", cmd_err, 1);
    #2 reset = 1'b0;
    #1 check_reset("rearm");
    @(negedge clk);

    // Phase 3: amplitude cut below the current position reverses without overshoot.
    push_step(4, 1, 1);   push_step(8, 2, 1);   push_step(12, 3, 1);
    push_step(16, 4, 1);  push_step(20, 5, 1);  push_step(24, 4, 0);
    push_step(28, 3, 0);  push_step(32, 2, 0);  push_step(36, 1, 0);
    push_step(40, 0, 0);  push_step(44, -1, 0); push_step(48, -2, 0);
    push_step(52, -3, 0); push_step(56, -4, 0); push_step(60, -3, 1);
    push_set(64, 7, 0); push_set(64, 6, 0); push_set(64, 5, 0); push_set(64, 4, 0);
    chk_steps = 1'b1;
    reset = 1'b1;
    drive_at(8, 0, 0, 1); drive_at(12, 0, 0, 1);
    drive_at(16, 0, 0, 1); drive_at(20, 0, 0, 1);
    wait_cyc(61);
    chk_steps = 1'b0;
    repeat (8) @(negedge clk);

    check("step_q empty", step_q.size(), 0);
    check("set_q empty",  set_q.size(),  0);
    check("st_q empty",   st_q.size(),   0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rock_driver.md
Name: rock_driver

Overview:
Cradle actuator driver; the consumer of the rocking path commands Fmin / Fplus / Amin issued by the controller.
- Holds a frequency and an amplitude setting and adjusts them from the commands.
- Generates step/dir pulses that swing the cradle symmetrically about centre.
- Reports its settings, motion state and command conflicts back to the controller.

Parameters:
FREQ_W, 8, width of frequency setting (phase increment)
AMP_W, 4, width of amplitude setting (steps either side of centre)
ACC_W, 16, phase accumulator width; step rate = freq / 2^ACC_W per clk
FREQ_MIN, 8, lower saturation of freq
FREQ_MAX, 200, upper saturation of freq
FREQ_INIT, 64, freq after reset
AMP_INIT, 8, amp after reset and on restart
UPD_DIV, 1024, clk cycles between command samples (>= 2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
Fmin  in  1  command: decrease frequency
Fplus  in  1  command: increase frequency
Amin  in  1  command: decrease amplitude
step  out  1  one-clk step pulse to motor stage
dir  out  1  1 = moving positive, 0 = moving negative
freq  out  FREQ_W  current frequency setting
amp  out  AMP_W  current amplitude setting
pos  out  AMP_W+1  signed position offset from centre
state  out  2  00 IDLE, 01 ROCK, 10 HOME
cmd_err  out  1  sticky: >1 command asserted at a sample

Behaviour:
Reset (reset=0, async):
- freq=FREQ_INIT, amp=AMP_INIT, pos=0, dir=1, step=0, state=ROCK, cmd_err=0.
- Accumulator and update counter cleared.
- Release is synchronous to the first clk edge with reset=1.

Command sampling:
- upd_cnt counts 0..UPD_DIV-1; commands are sampled only on the cycle upd_cnt==UPD_DIV-1.
- Priority Fmin > Fplus > Amin; only the highest-priority asserted command is applied.
- Fmin: freq = max(freq-1, FREQ_MIN). Fplus: freq = min(freq+1, FREQ_MAX).
- Amin: amp = amp-1, saturating at 0.
- Fmin or Fplus sampled while state=IDLE additionally reloads amp=AMP_INIT and enters ROCK; freq is adjusted in the same cycle.
- Two or more commands high at a sample sets cmd_err=1. It clears only on reset.
- New settings are visible on the outputs one cycle after the sample edge.

Step generation (ROCK or HOME):
- acc <= acc + freq every clk, with the addition carried out at ACC_W+1 bits.
- The carry out of that addition is a step event. step is registered: it pulses the cycle after the carry.
- On each step event pos moves by +1 if dir=1 and by -1 if dir=0.

Direction:
- Evaluated on every step event, before the move.
- If dir=1 and pos >= amp: dir=0 and the move is -1.
- If dir=0 and pos <= -amp: dir=1 and the move is +1.
- This covers an amp reduction that leaves pos outside the new range: the cradle reverses immediately at the next step, with no overshoot.
- A reduction applied on the same cycle as a step takes effect on the next step.

State machine:
- ROCK -> HOME when amp becomes 0.
- In HOME, dir points toward 0 and stepping continues; HOME -> IDLE on the step that lands pos=0.
- In IDLE: acc is held at 0, no steps, pos=0.
- HOME -> ROCK on restart (Fmin/Fplus) without passing through IDLE. Swing resumes from the current pos.

Boundary conditions:
- freq never leaves [FREQ_MIN, FREQ_MAX].
- |pos| <= AMP_INIT at all times.
- Commands between samples are ignored.
- The update counter free-runs in all states.

Decomposition:
- Package rock_pkg holds: state encoding enum (IDLE/ROCK/HOME), command priority constants, and default FREQ/AMP constants shared with the controller.
- One natural sub-module, rock_step_gen: the phase accumulator plus the registered step pulse.
- Settings, position and FSM stay in the top module.

Test Plan:
1. Reset mid-swing (UPD_DIV=4, freq=64, ACC_W=8) -> all outputs return to reset values immediately, before the next clk edge. After release the first step comes 4 clks later; pos 0->1.
2. Fplus held for 200 samples from freq=64 -> freq reaches 200 and stays there, no wrap. Fmin held -> freq reaches 8 and stays there.
3. Amin ×8 from amp=8 while pos=+6 and dir=1 (one sample, amp 8->7) -> the swing turns at +7. Further Amin down to amp=0 -> state=HOME; pos steps back to 0; state=IDLE; step stays low afterwards.
4. Amin drops amp from 8 to 3 while pos=+6 and dir=1 -> the next step gives dir=0 and pos=5. No pos=7 is ever observed.
5. In IDLE, Fmin sampled -> amp=8, freq decremented by 1, state=ROCK, stepping resumes with dir=1.
6. Fmin and Amin high together at a sample -> only freq changes, amp unchanged, cmd_err=1. cmd_err stays 1 through later clean samples until reset.
